// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter in front of one request/write/read slave channel.
// A grant covers a whole transaction (request acceptance plus all data beats).
//
// Parameters:
//   RR             1 = round-robin on a tie, 0 = master 0 always wins a tie
// Ports:
//   clk_i, rst_i   clock (rising edge), asynchronous active-low reset
//   mN_req_*       master N request channel (valid/ready, len, mask, addr, we)
//   mN_write_*     master N write-beat strobe and data (no backpressure)
//   mN_read_*      master N read beat (valid/data out, ack in)
//   s_req_*        slave request channel
//   s_write_*      slave write beats
//   s_read_*       slave read beats (valid/data in, ack out)
//   grant          one-hot transaction owner, 00 when idle
//   busy           a transaction is in progress
module bus_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Master 0 (CPU bus interface)
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [2:0]  m0_req_len,
  input  logic [3:0]  m0_req_mask,
  input  logic [31:0] m0_req_addr,
  input  logic        m0_req_we,
  input  logic        m0_write_valid,
  input  logic [31:0] m0_write_data,
  output logic        m0_read_valid,
  output logic [31:0] m0_read_data,
  input  logic        m0_read_ack,
  // Master 1 (secondary requester)
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [2:0]  m1_req_len,
  input  logic [3:0]  m1_req_mask,
  input  logic [31:0] m1_req_addr,
  input  logic        m1_req_we,
  input  logic        m1_write_valid,
  input  logic [31:0] m1_write_data,
  output logic        m1_read_valid,
  output logic [31:0] m1_read_data,
  input  logic        m1_read_ack,
  // Slave side
  output logic        s_req_valid,
  input  logic        s_req_ready,
  output logic [2:0]  s_req_len,
  output logic [3:0]  s_req_mask,
  output logic [31:0] s_req_addr,
  output logic        s_req_we,
  output logic        s_write_valid,
  output logic [31:0] s_write_data,
  input  logic        s_read_valid,
  input  logic [31:0] s_read_data,
  output logic        s_read_ack,
  // Status
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StReq, StData} state_e;

  state_e      state;
  logic [2:0]  cnt;
  logic        last;      // index of the master that owned the previous transaction
  logic [2:0]  lat_len;
  logic [3:0]  lat_mask;
  logic [31:0] lat_addr;
  logic        lat_we;

  // Arbitration and selected request fields
  logic        pick_m1;
  logic [2:0]  w_len;
  logic [3:0]  w_mask;
  logic [31:0] w_addr;
  logic        w_we;

  // Data-phase routing
  logic        in_data;
  logic        wr_path;
  logic        rd_path;
  logic        g_write_valid;
  logic [31:0] g_write_data;
  logic        g_read_ack;
  logic        beat;

  always_comb begin
    pick_m1 = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      // On a tie the master that did not own the last transaction wins.
      pick_m1 = RR ? ~last : 1'b0;
    end else begin
      pick_m1 = m1_req_valid;
    end
    w_len  = pick_m1 ? m1_req_len  : m0_req_len;
    w_mask = pick_m1 ? m1_req_mask : m0_req_mask;
    w_addr = pick_m1 ? m1_req_addr : m0_req_addr;
    w_we   = pick_m1 ? m1_req_we   : m0_req_we;
  end

  always_comb begin
    in_data       = (state == StData);
    wr_path       = in_data & lat_we;
    rd_path       = in_data & ~lat_we;
    g_write_valid = grant[1] ? m1_write_valid : m0_write_valid;
    g_write_data  = grant[1] ? m1_write_data  : m0_write_data;
    g_read_ack    = grant[1] ? m1_read_ack    : m0_read_ack;

    s_req_valid   = (state == StReq);
    s_req_len     = lat_len;
    s_req_mask    = lat_mask;
    s_req_addr    = lat_addr;
    s_req_we      = lat_we;
    m0_req_ready  = s_req_valid & grant[0] & s_req_ready;
    m1_req_ready  = s_req_valid & grant[1] & s_req_ready;

    s_write_valid = wr_path & g_write_valid;
    s_write_data  = wr_path ? g_write_data : 32'h0;
    s_read_ack    = rd_path & g_read_ack;

    m0_read_valid = rd_path & grant[0] & s_read_valid;
    m0_read_data  = (rd_path & grant[0]) ? s_read_data : 32'h0;
    m1_read_valid = rd_path & grant[1] & s_read_valid;
    m1_read_data  = (rd_path & grant[1]) ? s_read_data : 32'h0;

    beat          = s_write_valid | s_read_ack;
    busy          = (state != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= StIdle;
      grant    <= 2'b00;
      cnt      <= 3'd0;
      last     <= 1'b1;
      lat_len  <= 3'd0;
      lat_mask <= 4'h0;
      lat_addr <= 32'h0;
      lat_we   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (m0_req_valid || m1_req_valid) begin
            grant    <= pick_m1 ? 2'b10 : 2'b01;
            lat_len  <= w_len;
            lat_mask <= w_mask;
            lat_addr <= w_addr;
            lat_we   <= w_we;
            cnt      <= (w_len == 3'd0) ? 3'd1 : w_len;
            state    <= StReq;
          end
        end
        StReq: begin
          if (s_req_ready) begin
            state <= StData;
          end
        end
        StData: begin
          if (beat) begin
            if (cnt == 3'd1) begin
              state <= StIdle;
              grant <= 2'b00;
              last  <= grant[1];
              cnt   <= 3'd0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
